// File: rtl/ft_recovery_module.sv
// Lockstep fault-tolerance monitor for two RV32 cores.
// Compares both cores' regfile writebacks and checkpoints agreed state.
// On a mismatch it resets both cores, then requests debug so a recovery
// routine can read the checkpoint back through a small data port.
module ft_recovery_module #(
    parameter int          RESET_CYCLES = 2,
    parameter logic [31:0] PC_ADDR      = 32'h80
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_a_i,
    input  logic        we_b_i,
    input  logic [4:0]  addr_a_i,
    input  logic [4:0]  addr_b_i,
    input  logic [31:0] data_a_i,
    input  logic [31:0] data_b_i,
    input  logic [31:0] pc_i,
    input  logic        enable_i,
    input  logic        valid_instr_exec_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        done_i,
    input  logic        force_error_i,
    output logic        recover_o,
    output logic        reset_o,
    output logic        recovering_o,
    output logic        error_o
);

    localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RESET, RECOVER, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               reset_q, reset_d;
    logic               recover_q, recover_d;
    logic               recovering_q, recovering_d;
    logic [31:0]        shadow_q [32];
    logic [31:0]        shadow_d [32];
    logic [31:0]        saved_pc_q, saved_pc_d;
    logic               rvalid_q, rvalid_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               mismatch;
    logic               pc_sel;
    logic               reg_sel;
    logic [4:0]         reg_idx;
    logic [31:0]        rd_val;
    logic               unused_addr_lsb;

    // Merge write data into an existing word under byte enables.
    function automatic logic [31:0] apply_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Sub-word address bits carry no meaning on the word-wide recovery port.
    assign unused_addr_lsb = ^data_addr_i[1:0];

    // Lockstep comparison; only a mismatch seen in IDLE is reported.
    always_comb begin
        mismatch = (enable_i & ((we_a_i != we_b_i) |
                   (we_a_i & ((addr_a_i != addr_b_i) | (data_a_i != data_b_i)))))
                   | force_error_i;
        error_o  = mismatch & (state_q == IDLE);
    end

    // Recovery port address decode and read mux.
    always_comb begin
        pc_sel     = (data_addr_i == PC_ADDR);
        reg_sel    = (data_addr_i[31:7] == 25'd0);
        reg_idx    = data_addr_i[6:2];
        rd_val     = pc_sel ? saved_pc_q : shadow_q[reg_idx];
        data_gnt_o = data_req_i & recovering_q;
    end

    // Checkpoint updates (IDLE) and recovery-port accesses (recovering).
    always_comb begin
        shadow_d   = shadow_q;
        saved_pc_d = saved_pc_q;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        // With comparison disabled nothing is verified, so nothing is checkpointed.
        if ((state_q == IDLE) && enable_i && !mismatch) begin
            if (we_a_i && (addr_a_i != 5'd0)) shadow_d[addr_a_i] = data_a_i;
            if (valid_instr_exec_i)           saved_pc_d = pc_i;
        end
        if (data_gnt_o) begin
            rvalid_d = 1'b1;
            if (!pc_sel && !reg_sel) begin
                err_d   = 1'b1;
                rdata_d = 32'd0;
            end else if (data_we_i) begin
                if (pc_sel) begin
                    saved_pc_d = apply_be(saved_pc_q, data_wdata_i, data_be_i);
                end else if (reg_idx != 5'd0) begin
                    shadow_d[reg_idx] = apply_be(shadow_q[reg_idx], data_wdata_i, data_be_i);
                end
            end else begin
                rdata_d = rd_val;
            end
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mismatch) begin
                    state_d = RESET;
                    cnt_d   = '0;
                end
            end
            RESET: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) state_d = RECOVER;
                else                                    cnt_d   = cnt_q + 1'b1;
            end
            RECOVER: begin
                // A granted request in the same cycle wins so its response is not lost.
                if (data_gnt_o)  state_d = WAIT_DONE;
                else if (done_i) state_d = IDLE;
            end
            WAIT_DONE: begin
                if (done_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        reset_d      = (state_d == RESET);
        recover_d    = (state_d == RECOVER);
        recovering_d = (state_d == RECOVER) || (state_d == WAIT_DONE);
    end

    // FSM state, control outputs and port response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            reset_q      <= 1'b0;
            recover_q    <= 1'b0;
            recovering_q <= 1'b0;
            rvalid_q     <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reset_q      <= reset_d;
            recover_q    <= recover_d;
            recovering_q <= recovering_d;
            rvalid_q     <= rvalid_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Shadow register file and saved PC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) shadow_q[i] <= 32'd0;
            saved_pc_q <= 32'd0;
        end else begin
            for (int i = 0; i < 32; i++) shadow_q[i] <= shadow_d[i];
            saved_pc_q <= saved_pc_d;
        end
    end

    assign reset_o       = reset_q;
    assign recover_o     = recover_q;
    assign recovering_o  = recovering_q;
    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = err_q;
    assign data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_ft_recovery_module.sv
// Directed, table-driven bench for ft_recovery_module.
module tb_ft_recovery_module;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        we_a_i, we_b_i;
    logic [4:0]  addr_a_i, addr_b_i;
    logic [31:0] data_a_i, data_b_i, pc_i;
    logic        enable_i, valid_instr_exec_i;
    logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        data_err_o, done_i, force_error_i;
    logic        recover_o, reset_o, recovering_o, error_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    ft_recovery_module #(.RESET_CYCLES(2), .PC_ADDR(32'h80)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .we_a_i(we_a_i), .we_b_i(we_b_i),
        .addr_a_i(addr_a_i), .addr_b_i(addr_b_i),
        .data_a_i(data_a_i), .data_b_i(data_b_i),
        .pc_i(pc_i), .enable_i(enable_i),
        .valid_instr_exec_i(valid_instr_exec_i),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .data_err_o(data_err_o), .done_i(done_i),
        .force_error_i(force_error_i), .recover_o(recover_o),
        .reset_o(reset_o), .recovering_o(recovering_o), .error_o(error_o)
    );

    // exp bits: {error, gnt, reset, recover, recovering, rvalid, data_err}
    typedef struct {
        string       name;
        logic        en, we_a;
        logic [4:0]  ad_a;
        logic [31:0] d_a;
        logic        we_b;
        logic [4:0]  ad_b;
        logic [31:0] d_b;
        logic        vld;
        logic [31:0] pc;
        logic        frc, req, dwe;
        logic [31:0] daddr, wd;
        logic [3:0]  be;
        logic        done;
        logic [6:0]  exp;
        logic        chk;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl[$];
    int   n_first;

    function automatic vec_t zero(string n, logic [6:0] e);
        vec_t v;
        v.name = n; v.en = 1'b0; v.we_a = 1'b0; v.ad_a = 5'd0; v.d_a = 32'd0;
        v.we_b = 1'b0; v.ad_b = 5'd0; v.d_b = 32'd0; v.vld = 1'b0; v.pc = 32'd0;
        v.frc = 1'b0; v.req = 1'b0; v.dwe = 1'b0; v.daddr = 32'd0; v.wd = 32'd0;
        v.be = 4'd0; v.done = 1'b0; v.exp = e; v.chk = 1'b0; v.erd = 32'd0;
        return v;
    endfunction

    function automatic vec_t core(string n, logic en, logic wa, logic [4:0] aa, logic [31:0] da,
                                  logic wb, logic [4:0] ab, logic [31:0] db,
                                  logic vld, logic [31:0] pc, logic frc, logic [6:0] e);
        vec_t v;
        v = zero(n, e);
        v.en = en; v.we_a = wa; v.ad_a = aa; v.d_a = da;
        v.we_b = wb; v.ad_b = ab; v.d_b = db; v.vld = vld; v.pc = pc; v.frc = frc;
        return v;
    endfunction

    function automatic vec_t port(string n, logic we, logic [31:0] a, logic [31:0] wd,
                                  logic [3:0] be, logic [6:0] e, logic chk, logic [31:0] rd);
        vec_t v;
        v = zero(n, e);
        v.req = 1'b1; v.dwe = we; v.daddr = a; v.wd = wd; v.be = be;
        v.chk = chk; v.erd = rd;
        return v;
    endfunction

    function automatic vec_t ctl(string n, logic frc, logic done, logic [6:0] e);
        vec_t v;
        v = zero(n, e);
        v.frc = frc; v.done = done;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        enable_i = v.en; we_a_i = v.we_a; addr_a_i = v.ad_a; data_a_i = v.d_a;
        we_b_i = v.we_b; addr_b_i = v.ad_b; data_b_i = v.d_b;
        valid_instr_exec_i = v.vld; pc_i = v.pc; force_error_i = v.frc;
        data_req_i = v.req; data_we_i = v.dwe; data_addr_i = v.daddr;
        data_wdata_i = v.wd; data_be_i = v.be; done_i = v.done;
    endtask

    task automatic run_row(vec_t v);
        drive(v);
        #2;
        chk({v.name, ".error"}, 32'(error_o), 32'(v.exp[6]));
        chk({v.name, ".gnt"},   32'(data_gnt_o), 32'(v.exp[5]));
        @(posedge clk_i);
        #1;
        chk({v.name, ".reset"},      32'(reset_o),       32'(v.exp[4]));
        chk({v.name, ".recover"},    32'(recover_o),     32'(v.exp[3]));
        chk({v.name, ".recovering"}, 32'(recovering_o),  32'(v.exp[2]));
        chk({v.name, ".rvalid"},     32'(data_rvalid_o), 32'(v.exp[1]));
        chk({v.name, ".derr"},       32'(data_err_o),    32'(v.exp[0]));
        if (v.chk) chk({v.name, ".rdata"}, data_rdata_o, v.erd);
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, ".reset"},      32'(reset_o), 32'd0);
        chk({nm, ".recover"},    32'(recover_o), 32'd0);
        chk({nm, ".recovering"}, 32'(recovering_o), 32'd0);
        chk({nm, ".error"},      32'(error_o), 32'd0);
        chk({nm, ".gnt"},        32'(data_gnt_o), 32'd0);
        chk({nm, ".rvalid"},     32'(data_rvalid_o), 32'd0);
        chk({nm, ".derr"},       32'(data_err_o), 32'd0);
        chk({nm, ".rdata"},      data_rdata_o, 32'd0);
    endtask

    initial begin
        // Part 1: checkpointing, mismatch, recovery reads/writes, FSM paths.
        tbl.push_back(core("clean_x5", 1'b1, 1'b1, 5'd5, 32'h1234, 1'b1, 5'd5, 32'h1234, 1'b1, 32'h20, 1'b0, 7'b0000000));
        tbl.push_back(core("clean_x7", 1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 32'h77, 1'b0, 32'h0, 1'b0, 7'b0000000));
        tbl.push_back(core("en_off_mism", 1'b0, 1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 1'b1, 32'h99, 1'b0, 7'b0000000));
        tbl.push_back(core("ab_mism", 1'b1, 1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 1'b1, 32'h99, 1'b0, 7'b1010000));
        tbl.push_back(ctl("rst_hold", 1'b0, 1'b0, 7'b0010000));
        tbl.push_back(ctl("to_recover", 1'b0, 1'b0, 7'b0001100));
        tbl.push_back(port("rd_x5", 1'b0, 32'h14, 32'h0, 4'h0, 7'b0100110, 1'b1, 32'h1234));
        tbl.push_back(port("rd_x7", 1'b0, 32'h1C, 32'h0, 4'h0, 7'b0100110, 1'b1, 32'h77));
        tbl.push_back(port("rd_pc", 1'b0, 32'h80, 32'h0, 4'h0, 7'b0100110, 1'b1, 32'h20));
        tbl.push_back(port("rd_bad", 1'b0, 32'h200, 32'h0, 4'h0, 7'b0100111, 1'b1, 32'h0));
        tbl.push_back(port("wr_x0", 1'b1, 32'h0, 32'hFFFF, 4'hF, 7'b0100110, 1'b0, 32'h0));
        tbl.push_back(port("rd_x0", 1'b0, 32'h0, 32'h0, 4'h0, 7'b0100110, 1'b1, 32'h0));
        tbl.push_back(core("mism_wait", 1'b1, 1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 7'b0000100));
        tbl.push_back(port("wr_x5_be", 1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, 7'b0100110, 1'b0, 32'h0));
        tbl.push_back(port("rd_x5_be", 1'b0, 32'h14, 32'h0, 4'h0, 7'b0100110, 1'b1, 32'h00BB12DD));
        tbl.push_back(ctl("done_wait", 1'b0, 1'b1, 7'b0000000));
        tbl.push_back(ctl("done_idle", 1'b0, 1'b1, 7'b0000000));
        tbl.push_back(core("clean_pc40", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h40, 1'b0, 7'b0000000));
        tbl.push_back(core("force_pulse", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h99, 1'b1, 7'b1010000));
        tbl.push_back(port("req_in_reset", 1'b0, 32'h80, 32'h0, 4'h0, 7'b0010000, 1'b0, 32'h0));
        tbl.push_back(ctl("to_recover2", 1'b0, 1'b0, 7'b0001100));
        tbl.push_back(core("mism_recover", 1'b1, 1'b1, 5'd2, 32'h5, 1'b1, 5'd2, 32'h6, 1'b0, 32'h0, 1'b0, 7'b0001100));
        tbl.push_back(port("rd_pc40", 1'b0, 32'h80, 32'h0, 4'h0, 7'b0100110, 1'b1, 32'h40));
        tbl.push_back(ctl("done2", 1'b0, 1'b1, 7'b0000000));
        tbl.push_back(ctl("force_held", 1'b1, 1'b0, 7'b1010000));
        tbl.push_back(ctl("force_in_rst", 1'b1, 1'b0, 7'b0010000));
        tbl.push_back(ctl("to_recover3", 1'b0, 1'b0, 7'b0001100));
        tbl.push_back(ctl("done_first", 1'b0, 1'b1, 7'b0000000));
        tbl.push_back(ctl("force_again", 1'b1, 1'b0, 7'b1010000));
        tbl.push_back(ctl("rst_hold4", 1'b0, 1'b0, 7'b0010000));
        tbl.push_back(ctl("to_recover4", 1'b0, 1'b0, 7'b0001100));
        tbl.push_back(port("rd_x5_again", 1'b0, 32'h14, 32'h0, 4'h0, 7'b0100110, 1'b1, 32'h00BB12DD));
        n_first = tbl.size();
        // Part 2: after an asynchronous reset in WAIT_DONE.
        tbl.push_back(ctl("p2_force", 1'b1, 1'b0, 7'b1010000));
        tbl.push_back(ctl("p2_rst_hold", 1'b0, 1'b0, 7'b0010000));
        tbl.push_back(ctl("p2_to_recover", 1'b0, 1'b0, 7'b0001100));
        tbl.push_back(port("p2_rd_x5_clr", 1'b0, 32'h14, 32'h0, 4'h0, 7'b0100110, 1'b1, 32'h0));
        tbl.push_back(port("p2_rd_pc_clr", 1'b0, 32'h80, 32'h0, 4'h0, 7'b0100110, 1'b1, 32'h0));
        tbl.push_back(ctl("p2_done_force", 1'b1, 1'b1, 7'b0000000));
        tbl.push_back(ctl("p2_retrigger", 1'b1, 1'b0, 7'b1010000));
        tbl.push_back(ctl("p2_rst_hold2", 1'b0, 1'b0, 7'b0010000));
        tbl.push_back(ctl("p2_to_recover2", 1'b0, 1'b0, 7'b0001100));
        tbl.push_back(ctl("p2_done", 1'b0, 1'b1, 7'b0000000));

        // Power-on reset
        drive(zero("nop", 7'b0));
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk_all_zero("por");
        rst_i = 1'b0;

        for (int i = 0; i < n_first; i++) run_row(tbl[i]);

        // Asynchronous reset while in WAIT_DONE with a response pending
        drive(zero("nop", 7'b0));
        #2;
        rst_i = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk_i);
        #1;
        chk_all_zero("async_rst_held");
        rst_i = 1'b0;

        for (int i = n_first; i < tbl.size(); i++) run_row(tbl[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ft_recovery_module.md
Name: ft_recovery_module

Overview:
- Lockstep fault-tolerance monitor for two identical RV32 cores executing the same program.
- Compares both cores' register-file writeback every cycle and checkpoints the agreed state in a shadow register file, together with the PC of the last valid instruction.
- On a mismatch, it resets both cores and then raises a debug request. The cores' recovery routine (at the debug halt address) then reads the checkpoint through a dedicated data-memory port and signals completion.

Parameters:
- RESET_CYCLES, 2, number of cycles reset_o is held high after an error.
- PC_ADDR, 32'h80, byte address of the saved-PC word on the recovery data port.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active high.
- we_a_i / we_b_i  in  1  regfile write enable, core A / core B.
- addr_a_i / addr_b_i  in  5  regfile write address, core A / B.
- data_a_i / data_b_i  in  32  regfile write data, core A / B.
- pc_i  in  32  PC of core A's instruction in ID.
- enable_i  in  1  comparison enable.
- valid_instr_exec_i  in  1  core A ID stage holds a valid executing instruction.
- data_req_i  in  1  recovery-port request.
- data_gnt_o  out  1  request grant.
- data_rvalid_o  out  1  response valid.
- data_we_i  in  1  write enable.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  byte address.
- data_wdata_i  in  32  write data.
- data_rdata_o  out  32  read data.
- data_err_o  out  1  access error.
- done_i  in  1  recovery routine finished.
- force_error_i  in  1  inject a mismatch (test).
- recover_o  out  1  debug request to both cores.
- reset_o  out  1  reset to both cores, active high.
- recovering_o  out  1  recovery in progress; steers core data traffic to this port.
- error_o  out  1  mismatch detected.

Behaviour:

Reset values:
- All outputs 0; FSM = IDLE; shadow regs and saved PC = 0.

Mismatch (combinational):
- mismatch = enable_i & ((we_a_i != we_b_i) | (we_a_i & (addr_a_i != addr_b_i | data_a_i != data_b_i))) | force_error_i.
- error_o = mismatch & (state == IDLE). Mismatches in any other state are ignored.

Checkpoint (IDLE only, no mismatch in that cycle):
- If we_a_i and addr_a_i != 0: shadow[addr_a_i] <= data_a_i. x0 always reads 0.
- If valid_instr_exec_i: saved_pc <= pc_i.
- Any cycle with a mismatch updates neither shadow nor saved_pc.

FSM:
- IDLE: on mismatch -> RESET.
- RESET: reset_o = 1 for RESET_CYCLES cycles (counter), then -> RECOVER.
- RECOVER: recover_o = 1 and recovering_o = 1. Go to WAIT_DONE on the first accepted data_req_i; go directly to IDLE if done_i arrives first.
- WAIT_DONE: recovering_o = 1 and recover_o = 0; on done_i -> IDLE.
- recovering_o is 0 in IDLE and RESET.
- done_i in IDLE or RESET is ignored.
- force_error_i held high re-triggers recovery immediately after returning to IDLE.

Recovery data port (recovering_o = 1 only):
- Grant: data_gnt_o = data_req_i, combinational.
- Response: data_rvalid_o pulses the cycle after the grant.
- Addresses 0x00–0x7C: word index addr[6:2] selects shadow reg x0–x31.
- Address PC_ADDR: selects saved_pc.
- Reads: data_rdata_o is registered, valid with rvalid.
- Writes: apply byte enables data_be_i to the shadow reg or saved_pc; writes to x0 are ignored.
- Any other address: rvalid with data_err_o = 1, rdata = 0, no write.
- When not recovering: gnt, rvalid and err are all 0, and requests are ignored.
- rdata holds its last value when rvalid is 0.

Reset mid-operation:
- rst_i at any time returns the FSM to IDLE and clears shadow state and all outputs asynchronously.

Test Plan:
- Both cores write x5 = 0x1234 with enable_i = 1 → error_o = 0; a read of 0x14 during a later recovery returns 0x00001234.
- Core A writes x7 = 0xA, core B writes x7 = 0xB → error_o = 1 for one cycle; reset_o high for exactly 2 cycles; then recover_o = 1 and recovering_o = 1; x7 shadow stays at its old value.
- pc_i = 0x40 with valid_instr_exec_i = 1 in clean cycles, then force_error_i pulse → a read of 0x80 returns 0x40; data_gnt_o is asserted the same cycle and data_rvalid_o one cycle later.
- During WAIT_DONE: a read of 0x200 → data_err_o = 1; a write of 0xFFFF to x0 → x0 still reads 0; done_i → IDLE with all control outputs 0.
- A mismatch during RECOVER or WAIT_DONE → no error_o, no restart; with enable_i = 0, mismatched writes → no error and no checkpoint.
- Assert rst_i in WAIT_DONE → all outputs 0 immediately; the FSM is in IDLE.
